ifu_fetch_ctrl: RTL
===================

# ifu_fetch_ctrl

Instruction-fetch controller for the NPC core. It sequences single-outstanding fetches to instruction memory and holds the returned word in an instruction register. That register feeds the pre-decoder/decoder through a valid/ready handshake. It also owns the PC's sequential advance and applies redirects (branch/jump/trap) from execute, squashing any fetch in flight.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC / fetch address width.
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013: word presented on a fault (`addi x0,x0,0`).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  ADDR_WIDTH  fetch address; sampled by memory only in the cycle `imem_req && imem_gnt`.
- `imem_gnt`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  response valid; never asserted in the same cycle as the matching `imem_gnt`.
- `imem_rdata`  in  `DATA_WIDTH`  fetched instruction word.
- `imem_err`  in  1  access fault; qualified by `imem_rvalid`.
- `redirect_valid`  in  1  PC redirect request.
- `redirect_pc`  in  ADDR_WIDTH  redirect target.
- `inst_valid`  out  1  `inst`/`inst_pc`/`inst_fault` valid to decode.
- `inst`  out  `DATA_WIDTH`  instruction register, feeding the pre-decoder.
- `inst_pc`  out  ADDR_WIDTH  PC of `inst`.
- `inst_fault`  out  1  fetch faulted (misaligned or `imem_err`); `inst` = NOP_INSTR.
- `inst_ready`  in  1  decode consumes `inst` this cycle.
- `fetch_cnt`  out  32  count of instructions handed off (`inst_valid && inst_ready`, not squashed).

## Operation
- States: IDLE, REQ, WAIT, HOLD. Registers: `pc`, `kill`, IR fields, `fetch_cnt`.
- Reset (`rst_n`=0 at edge): state=IDLE, pc=RESET_PC, kill=0, inst=NOP_INSTR, inst_pc=RESET_PC, inst_valid=0, inst_fault=0, fetch_cnt=0. Outputs: imem_req=0, imem_addr=pc.
- `imem_req` = (state==REQ). `imem_addr` = pc. `inst_valid` = (state==HOLD).
- IDLE: go to REQ unconditionally.
- REQ:
  - redirect and gnt in the same cycle: the old address was accepted. Set kill=1, pc<=redirect_pc, go to WAIT.
  - redirect without gnt: pc<=redirect_pc, stay in REQ (new address next cycle).
  - gnt only: go to WAIT.
- WAIT:
  - redirect (any cycle, including the rvalid cycle): pc<=redirect_pc, kill<=1. Last redirect wins.
  - rvalid with kill or redirect in the same cycle: discard the response, kill<=0, go to REQ.
  - rvalid otherwise: inst<=imem_err ? NOP_INSTR : imem_rdata, inst_fault<=imem_err, inst_pc<=pc, go to HOLD.
- HOLD:
  - redirect: drop the instruction (no count), pc<=redirect_pc, go to REQ. A redirect beats `inst_ready` in the same cycle.
  - ready without redirect: fetch_cnt+=1, pc<=pc+4 (mod 2^ADDR_WIDTH, wraps), go to REQ.
  - neither: hold all IR fields stable.
- Misaligned target (`redirect_pc[1:0]`≠0), from any state: no memory request is issued. Go to HOLD with inst=NOP_INSTR, inst_fault=1, inst_pc=redirect_pc.
  - In WAIT, the pending response is still discarded. Stay in WAIT with kill=1 and a pending-fault flag; on rvalid, go to HOLD with the fault.
- A faulted instruction is consumed like any other: pc<=pc+4 on ready. Execute is expected to redirect.
- `fetch_cnt` wraps at 2^32.
- Reset mid-transaction returns to IDLE. Any late `imem_rvalid` after reset is ignored because kill is not carried across reset; memory is reset together with this block.

## Timing
- Best-case throughput: 1 instruction per 3 cycles.
  - t: REQ+gnt.
  - t+1: WAIT+rvalid.
  - t+2: HOLD, ready.
  - t+3: next REQ.
- First `imem_req` appears in the 2nd cycle after `rst_n` rises (IDLE lasts 1 cycle).
- Redirect at cycle t: `imem_addr`=redirect_pc from t+1. An aligned redirect never causes `inst_valid` before t+3.
- Misaligned redirect from REQ/HOLD: `inst_valid`=1 with fault at t+1.
- Memory stalls (gnt/rvalid low) hold state indefinitely. No timeout.
- All outputs except `imem_req`/`inst_valid` (state decodes) are registered.

## Test plan
- Reset, then gnt/rvalid every legal cycle and ready always high. Expect addresses 0x80000000, 0x80000004, 0x80000008 on the REQ cycles. Each instruction appears 2 cycles after its REQ cycle. `fetch_cnt`=3 after three handoffs.
- Backpressure: ready low for 5 HOLD cycles. `inst`/`inst_pc` stay stable, `imem_req`=0 throughout, and no pc advance.
- Redirect to 0x80000100 while in WAIT. The response (0xDEADBEEF) is discarded and never appears on `inst`. The next REQ address is 0x80000100.
- Redirect and `inst_ready` in the same HOLD cycle. `fetch_cnt` is unchanged and the next address is redirect_pc.
- Misaligned redirect to 0x80000102 in HOLD. Next cycle: inst_valid=1, inst_fault=1, inst=0x00000013, inst_pc=0x80000102, and no `imem_req`.
- `imem_err`=1 on rvalid at pc 0x80000010. Expect inst_fault=1, inst=0x00000013, and next fetch at 0x80000014 after ready.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: single-outstanding instruction fetch sequencer with
// an instruction register handed to decode over a valid/ready handshake.
module ifu_fetch_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_err,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_fault,
    input  logic                  inst_ready,
    output logic [31:0]           fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  kill_q;
    logic                  pf_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic [ADDR_WIDTH-1:0] inst_pc_q;
    logic                  inst_fault_q;
    logic [31:0]           cnt_q;
    logic                  redir_mis;

    // A redirect to a non word-aligned target never reaches memory.
    assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);

    assign imem_req   = (state_q == REQ);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;
    assign fetch_cnt  = cnt_q;

    // Fetch sequencer, PC, squash tracking and instruction register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            pf_q         <= 1'b0;
            inst_q       <= NOP_INSTR;
            inst_pc_q    <= RESET_PC;
            inst_fault_q <= 1'b0;
            cnt_q        <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        if (redir_mis) begin
                            inst_q       <= NOP_INSTR;
                            inst_fault_q <= 1'b1;
                            inst_pc_q    <= redirect_pc;
                            state_q      <= HOLD;
                        end
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        if (imem_gnt) begin
                            // Old address already accepted: squash its reply.
                            kill_q  <= 1'b1;
                            pf_q    <= redir_mis;
                            state_q <= WAIT;
                        end else if (redir_mis) begin
                            inst_q       <= NOP_INSTR;
                            inst_fault_q <= 1'b1;
                            inst_pc_q    <= redirect_pc;
                            state_q      <= HOLD;
                        end
                    end else if (imem_gnt) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc_q   <= redirect_pc;
                        kill_q <= 1'b1;
                        pf_q   <= redir_mis;
                    end
                    if (imem_rvalid) begin
                        kill_q <= 1'b0;
                        pf_q   <= 1'b0;
                        if (redirect_valid) begin
                            if (redir_mis) begin
                                inst_q       <= NOP_INSTR;
                                inst_fault_q <= 1'b1;
                                inst_pc_q    <= redirect_pc;
                                state_q      <= HOLD;
                            end else begin
                                state_q <= REQ;
                            end
                        end else if (kill_q) begin
                            if (pf_q) begin
                                inst_q       <= NOP_INSTR;
                                inst_fault_q <= 1'b1;
                                inst_pc_q    <= pc_q;
                                state_q      <= HOLD;
                            end else begin
                                state_q <= REQ;
                            end
                        end else begin
                            inst_q       <= imem_err ? NOP_INSTR : imem_rdata;
                            inst_fault_q <= imem_err;
                            inst_pc_q    <= pc_q;
                            state_q      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        // Redirect beats a same-cycle handoff.
                        pc_q <= redirect_pc;
                        if (redir_mis) begin
                            inst_q       <= NOP_INSTR;
                            inst_fault_q <= 1'b1;
                            inst_pc_q    <= redirect_pc;
                        end else begin
                            state_q <= REQ;
                        end
                    end else if (inst_ready) begin
                        cnt_q   <= cnt_q + 32'd1;
                        pc_q    <= pc_q + ADDR_WIDTH'(4);
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
